// File: rtl/linebuffer_span_writer_if.sv
// linebuffer_span_writer_if
//   Bundles the command side (span/clear requests, status) and the linebuffer
//   write port of the span writer into one interface.
//
//   Command / status group:
//     bank          buffer half for the next accepted span or clear
//     clear_req     single-cycle request to fill the selected half
//     clear_colour  background colour, sampled with clear_req
//     cmd_valid     span command valid
//     cmd_ready     writer can accept a span command
//     cmd_x         span start x
//     cmd_len       span length in pixels (0 is legal)
//     cmd_colour    span colour
//     busy          writer is clearing or drawing a span
//     done          one-cycle pulse when a span or clear completes
//   Linebuffer write port group:
//     addr_draw     write address {bank, x}
//     we_draw       write enable
//     colour_draw   write data
//
//   master : command source, sees the write port as inputs
//   slave  : the span writer itself
interface linebuffer_span_writer_if;
  logic        bank;
  logic        clear_req;
  logic [7:0]  clear_colour;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_len;
  logic [7:0]  cmd_colour;
  logic        busy;
  logic        done;
  logic [10:0] addr_draw;
  logic        we_draw;
  logic [7:0]  colour_draw;

  modport master (
    output bank, clear_req, clear_colour,
    output cmd_valid, cmd_x, cmd_len, cmd_colour,
    input  cmd_ready, busy, done,
    input  addr_draw, we_draw, colour_draw
  );

  modport slave (
    input  bank, clear_req, clear_colour,
    input  cmd_valid, cmd_x, cmd_len, cmd_colour,
    output cmd_ready, busy, done,
    output addr_draw, we_draw, colour_draw
  );
endinterface

// File: rtl/linebuffer_span_writer.sv
// linebuffer_span_writer
//   Draw-side producer for the 2048x8 pixel linebuffer. Accepts horizontal
//   span commands and line-clear requests and emits one pixel write per
//   clk_draw cycle into the half selected by addr_draw[10].
//
//   Ports:
//     clk_draw    draw clock, rising edge
//     rst_draw_n  synchronous active-low reset
//     lb          linebuffer_span_writer_if.slave (commands, status, write port)
//
//   Parameters:
//     LINE_WIDTH   visible pixels per line (1..1024); x >= LINE_WIDTH is clipped
//     TRANSPARENT  span colour treated as transparent
//     TRANSP_EN    1 = transparent span pixels are not written
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting; cmd_ready high unless a clear is being requested
//   CLEAR  | writing clear_colour to x = 0..LINE_WIDTH-1 of the half
//   SPAN   | writing the clipped span, one pixel per cycle
module linebuffer_span_writer #(
  parameter int         LINE_WIDTH  = 640,
  parameter logic [7:0] TRANSPARENT = 8'h00,
  parameter bit         TRANSP_EN   = 1'b1
) (
  input  logic                   clk_draw,
  input  logic                   rst_draw_n,
  linebuffer_span_writer_if.slave lb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SPAN  = 2'd2
  } state_t;

  localparam logic [10:0] LW = 11'(LINE_WIDTH);

  state_t      state_q, state_d;
  // Pixels still to write after the one currently presented; 0 = last pixel.
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  colour_q, colour_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  // Write enable applied to every pixel of the running operation; cleared
  // for transparent spans so addresses still step with no writes.
  logic        wen_q, wen_d;

  logic [10:0] x_ext;
  logic [10:0] len_ext;
  logic [10:0] avail;
  logic [10:0] span_n;
  logic        span_transp;
  logic        accept_span;

  // Clipped span length, computed in 11 bits so x + n never exceeds
  // LINE_WIDTH and the address can never wrap into the other half.
  always_comb begin
    x_ext       = {1'b0, lb.cmd_x};
    len_ext     = {1'b0, lb.cmd_len};
    avail       = (x_ext < LW) ? (LW - x_ext) : 11'd0;
    span_n      = (len_ext < avail) ? len_ext : avail;
    span_transp = TRANSP_EN && (lb.cmd_colour == TRANSPARENT);
  end

  // Ready has to drop in the same cycle a clear is requested so that a
  // simultaneous command is left pending instead of being handshaken away.
  assign lb.cmd_ready = (state_q == ST_IDLE) && !lb.clear_req && rst_draw_n;
  assign accept_span  = lb.cmd_valid && lb.cmd_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    colour_d = colour_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wen_d    = wen_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (lb.clear_req) begin
          state_d  = ST_CLEAR;
          cnt_d    = LW - 11'd1;
          addr_d   = {lb.bank, 10'd0};
          colour_d = lb.clear_colour;
          wen_d    = 1'b1;
          we_d     = 1'b1;
          busy_d   = 1'b1;
        end else if (accept_span) begin
          if (span_n == 11'd0) begin
            // Fully clipped or zero-length: complete on the next cycle.
            done_d = 1'b1;
          end else begin
            state_d  = ST_SPAN;
            cnt_d    = span_n - 11'd1;
            addr_d   = {lb.bank, lb.cmd_x};
            colour_d = lb.cmd_colour;
            wen_d    = !span_transp;
            we_d     = !span_transp;
            busy_d   = 1'b1;
          end
        end
      end

      ST_CLEAR, ST_SPAN: begin
        if (cnt_q == 11'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - 11'd1;
          addr_d = {addr_q[10], addr_q[9:0] + 10'd1};
          we_d   = wen_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_draw) begin
    if (!rst_draw_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 11'd0;
      addr_q   <= 11'd0;
      we_q     <= 1'b0;
      colour_q <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wen_q    <= wen_d;
    end
  end

  assign lb.addr_draw   = addr_q;
  assign lb.we_draw     = we_q;
  assign lb.colour_draw = colour_q;
  assign lb.busy        = busy_q;
  assign lb.done        = done_q;

endmodule

// File: tb/tb_linebuffer_span_writer.sv
// tb_linebuffer_span_writer
//   Directed bench for linebuffer_span_writer. A queue-based model expands
//   every accepted operation into its expected per-cycle outputs; a compare
//   process checks the DUT against it every cycle, and the directed sequences
//   add literal expectations at the interesting points.
module tb_linebuffer_span_writer;

  localparam int LW = 640;

  logic clk_draw;
  logic rst_draw_n;

  linebuffer_span_writer_if lb ();

  linebuffer_span_writer #(
    .LINE_WIDTH  (LW),
    .TRANSPARENT (8'h00),
    .TRANSP_EN   (1'b1)
  ) dut (
    .clk_draw   (clk_draw),
    .rst_draw_n (rst_draw_n),
    .lb         (lb)
  );

  initial begin
    clk_draw = 1'b0;
    forever #5 clk_draw = ~clk_draw;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    bit          chk_addr;
    logic [10:0] addr;
    logic [7:0]  colour;
    bit          busy;
    bit          done;
  } rec_t;

  rec_t exp_q[$];
  bit   model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: at each rising edge, an idle block takes a clear (priority) or a
  // span and lays out its whole output timeline.
  task automatic push_clear();
    for (int i = 0; i < LW; i++)
      exp_q.push_back('{1'b1, 1'b1, {lb.bank, 10'(i)}, lb.clear_colour, 1'b1, 1'b0});
    exp_q.push_back('{1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 1'b1});
  endtask

  task automatic push_span();
    int xi, li, n;
    bit wr;
    xi = int'(lb.cmd_x);
    li = int'(lb.cmd_len);
    if (xi < LW) n = (li < LW - xi) ? li : LW - xi;
    else         n = 0;
    wr = !(lb.cmd_colour == 8'h00);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{wr, 1'b1, {lb.bank, 10'(xi + i)}, lb.cmd_colour, 1'b1, 1'b0});
    exp_q.push_back('{1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 1'b1});
  endtask

  initial begin
    forever begin
      @(posedge clk_draw);
      model_on = 1'b1;
      if (!rst_draw_n) exp_q.delete();
      else if (exp_q.size() == 0) begin
        if (lb.clear_req)      push_clear();
        else if (lb.cmd_valid) push_span();
      end
    end
  end

  initial begin
    rec_t e;
    logic exp_ready;
    forever begin
      @(negedge clk_draw);
      if (model_on) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 1'b0};
        chk("cyc_we", lb.we_draw, e.we);
        chk("cyc_busy", lb.busy, e.busy);
        chk("cyc_done", lb.done, e.done);
        exp_ready = (exp_q.size() == 0) && !lb.clear_req && rst_draw_n;
        chk("cyc_ready", lb.cmd_ready, exp_ready);
        if (e.chk_addr) begin
          chk("cyc_addr", lb.addr_draw, e.addr);
          chk("cyc_colour", lb.colour_draw, e.colour);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_draw);
    #1;
  endtask

  task automatic send_span(input logic b, input logic [9:0] x, input logic [9:0] len,
                           input logic [7:0] col);
    lb.bank       = b;
    lb.cmd_x      = x;
    lb.cmd_len    = len;
    lb.cmd_colour = col;
    lb.cmd_valid  = 1'b1;
    tick();
    lb.cmd_valid  = 1'b0;
  endtask

  initial begin
    rst_draw_n      = 1'b0;
    lb.bank         = 1'b0;
    lb.clear_req    = 1'b0;
    lb.clear_colour = 8'h00;
    lb.cmd_valid    = 1'b1;
    lb.cmd_x        = 10'd3;
    lb.cmd_len      = 10'd2;
    lb.cmd_colour   = 8'h09;

    // Reset with a command held valid
    repeat (3) begin
      tick();
      chk("rst_we", lb.we_draw, 1'b0);
      chk("rst_done", lb.done, 1'b0);
      chk("rst_busy", lb.busy, 1'b0);
      chk("rst_ready", lb.cmd_ready, 1'b0);
    end
    rst_draw_n   = 1'b1;
    lb.cmd_valid = 1'b0;
    tick();
    chk("rel_ready", lb.cmd_ready, 1'b1);
    chk("rel_busy", lb.busy, 1'b0);

    // Basic span in the upper half
    send_span(1'b1, 10'd100, 10'd4, 8'h2A);
    for (int i = 0; i < 4; i++) begin
      chk("span_addr", lb.addr_draw, 11'h464 + 11'(i));
      chk("span_we", lb.we_draw, 1'b1);
      chk("span_col", lb.colour_draw, 8'h2A);
      chk("span_busy", lb.busy, 1'b1);
      tick();
    end
    chk("span_done", lb.done, 1'b1);
    chk("span_ready", lb.cmd_ready, 1'b1);
    chk("span_we_end", lb.we_draw, 1'b0);

    // Clipping at the right edge, then a span entirely off the line
    send_span(1'b0, 10'd638, 10'd5, 8'h5C);
    chk("clip_addr0", lb.addr_draw, 11'h27E);
    tick();
    chk("clip_addr1", lb.addr_draw, 11'h27F);
    tick();
    chk("clip_done", lb.done, 1'b1);
    send_span(1'b0, 10'd700, 10'd3, 8'h5C);
    chk("off_done", lb.done, 1'b1);
    chk("off_we", lb.we_draw, 1'b0);

    // Transparent span: timing kept, no writes; then an opaque one
    send_span(1'b0, 10'd10, 10'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("tr_we", lb.we_draw, 1'b0);
      chk("tr_busy", lb.busy, 1'b1);
      tick();
    end
    chk("tr_done", lb.done, 1'b1);
    send_span(1'b0, 10'd10, 10'd3, 8'h01);
    for (int i = 0; i < 3; i++) begin
      chk("op_we", lb.we_draw, 1'b1);
      chk("op_addr", lb.addr_draw, 11'd10 + 11'(i));
      tick();
    end
    chk("op_done", lb.done, 1'b1);

    // Zero-length span
    send_span(1'b1, 10'd20, 10'd0, 8'h44);
    chk("zero_done", lb.done, 1'b1);
    chk("zero_we", lb.we_draw, 1'b0);

    // Clear wins over a simultaneous command, which stays pending
    lb.bank         = 1'b0;
    lb.clear_colour = 8'h11;
    lb.clear_req    = 1'b1;
    lb.cmd_valid    = 1'b1;
    lb.cmd_x        = 10'd5;
    lb.cmd_len      = 10'd2;
    lb.cmd_colour   = 8'h33;
    #1;
    chk("clr_ready", lb.cmd_ready, 1'b0);
    tick();
    lb.clear_req    = 1'b0;
    lb.clear_colour = 8'h55;
    lb.bank         = 1'b1;
    chk("clr_addr0", lb.addr_draw, 11'h000);
    chk("clr_col0", lb.colour_draw, 8'h11);
    chk("clr_we0", lb.we_draw, 1'b1);
    for (int i = 1; i < LW; i++) begin
      tick();
      lb.clear_req = (i == 300);
    end
    chk("clr_addr_last", lb.addr_draw, 11'h27F);
    chk("clr_col_last", lb.colour_draw, 8'h11);
    tick();
    chk("clr_done", lb.done, 1'b1);
    chk("clr_ready_end", lb.cmd_ready, 1'b1);
    tick();
    lb.cmd_valid = 1'b0;
    chk("pend_addr0", lb.addr_draw, 11'h405);
    chk("pend_col", lb.colour_draw, 8'h33);
    tick();
    chk("pend_addr1", lb.addr_draw, 11'h406);
    tick();
    chk("pend_done", lb.done, 1'b1);

    // Reset in the middle of a span
    send_span(1'b0, 10'd0, 10'd10, 8'h07);
    chk("ab_addr0", lb.addr_draw, 11'h000);
    tick();
    chk("ab_addr1", lb.addr_draw, 11'h001);
    rst_draw_n = 1'b0;
    tick();
    chk("ab_we", lb.we_draw, 1'b0);
    chk("ab_busy", lb.busy, 1'b0);
    chk("ab_done", lb.done, 1'b0);
    tick();
    chk("ab_we2", lb.we_draw, 1'b0);
    rst_draw_n = 1'b1;
    tick();
    chk("ab_rel_done", lb.done, 1'b0);
    chk("ab_rel_ready", lb.cmd_ready, 1'b1);
    repeat (3) tick();

    send_span(1'b1, 10'd5, 10'd1, 8'hEE);
    chk("rec_addr", lb.addr_draw, 11'h405);
    chk("rec_we", lb.we_draw, 1'b1);
    tick();
    chk("rec_done", lb.done, 1'b1);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/linebuffer_span_writer.md
Name: linebuffer_span_writer

Overview:
- Draw-side producer for the 2048x8 pixel linebuffer. Drives its write port (addr_draw/we_draw/colour_draw) in the clk_draw domain.
- Accepts horizontal span commands (x, length, colour) and line-clear requests, and emits one pixel write per cycle into the selected half of the buffer.
- The half is chosen by addr_draw[10], so one half can be drawn while the pixel side scans out the other.

Parameters:
- LINE_WIDTH, 640, visible pixels per line; writes at x >= LINE_WIDTH are clipped; legal range 1..1024.
- TRANSPARENT, 8'h00, colour index treated as transparent in spans.
- TRANSP_EN, 1, 1 = span pixels whose colour equals TRANSPARENT are skipped (no write); 0 = always written.

Ports:
- clk_draw, in, 1, draw clock; all logic is on the rising edge.
- rst_draw_n, in, 1, synchronous active-low reset.
- bank, in, 1, buffer half for the next accepted span or clear; becomes addr_draw[10].
- clear_req, in, 1, single-cycle request to fill the selected half with clear_colour.
- clear_colour, in, 8, background colour; sampled with clear_req.
- cmd_valid, in, 1, span command valid.
- cmd_ready, out, 1, block can accept a command; high only in IDLE.
- cmd_x, in, 10, span start x.
- cmd_len, in, 10, span length in pixels; 0 is legal.
- cmd_colour, in, 8, span colour.
- busy, out, 1, high in CLEAR or SPAN.
- done, out, 1, one-cycle pulse when a span or clear completes.
- addr_draw, out, 11, linebuffer write address {bank, x}.
- we_draw, out, 1, linebuffer write enable.
- colour_draw, out, 8, linebuffer write data.

Behaviour:
- Reset, while rst_draw_n=0 at a clock edge:
  - State goes to IDLE.
  - we_draw=0, addr_draw=0, colour_draw=0, busy=0, done=0.
  - cmd_ready=0 during reset; cmd_ready=1 on the first cycle after release.
  - Reset mid-operation aborts the span/clear. No done pulse. we_draw is 0 from the cycle after the reset edge.
- All outputs are registered.
- States:
  - IDLE -> CLEAR on clear_req.
  - IDLE -> SPAN on cmd_valid&&cmd_ready, when clear_req=0.
  - CLEAR and SPAN -> IDLE after the last cycle.
  - cmd_ready = (state==IDLE) && !clear_req.
- Simultaneous clear_req and cmd_valid in IDLE: the clear wins; the command is not accepted and stays pending under valid/ready rules.
- clear_req outside IDLE is ignored; it is not queued.
- bank, clear_colour and the cmd_* fields are latched at the accept edge. Later changes do not affect an operation in progress.
- CLEAR, accepted at edge T:
  - Writes x = 0..LINE_WIDTH-1 on cycles T+1..T+LINE_WIDTH.
  - addr_draw = {bank, x}, colour_draw = clear_colour, we_draw=1.
  - done=1 and busy=0 at T+LINE_WIDTH+1; IDLE again at that cycle.
- SPAN, accepted at edge T:
  - n = min(cmd_len, LINE_WIDTH - cmd_x) when cmd_x < LINE_WIDTH, else n = 0. Compute in 11 bits; no wrap-around past x=1023 or into the other half.
  - Cycles T+1..T+n present addr_draw = {bank, cmd_x+i} for i = 0..n-1, with colour_draw = cmd_colour.
  - we_draw=1 on those cycles, except we_draw=0 throughout when TRANSP_EN && cmd_colour == TRANSPARENT. Addresses still step and timing is unchanged.
  - done=1 at T+n+1. For n=0 there are no writes and done=1 at T+1.
- busy=1 from T+1 until the cycle before done. busy=0 in the done cycle, where cmd_ready=1, so back-to-back commands have a one-cycle gap.
- we_draw=0 whenever not actively writing. addr_draw and colour_draw hold their last values when idle.
- Throughput: one pixel per clock. No stalls; the linebuffer write port is always ready.

Test Plan:
- Reset: hold rst_draw_n=0 three cycles with cmd_valid=1 -> we_draw=0, done=0, busy=0, cmd_ready=0 throughout; cmd_ready=1 the first cycle after release.
- Span: bank=1, x=100, len=4, colour=8'h2A, accepted at T -> writes addr 11'h464..11'h467 on T+1..T+4 with colour 2A; done at T+5; cmd_ready=1 at T+5.
- Clip: LINE_WIDTH=640, x=638, len=5 -> writes only 638 and 639; done at T+3. Then x=700, len=3 -> no writes, done at T+1.
- Transparent: colour=8'h00, len=3, TRANSP_EN=1 -> we_draw=0 throughout, done at T+4. Same command with colour=8'h01 -> three writes.
- Clear: clear_req and cmd_valid asserted together, bank=0, clear_colour=8'h11 -> cmd not accepted; writes addr 0..639 with colour 11; done at T+641; pending cmd accepted the next cycle.
- Abort: reset asserted at T+2 of a len=10 span -> no writes from T+3 on, no done pulse, IDLE with cmd_ready=1 after release.
